// File: rtl/cu_bist_if.sv
// Control unit boundary: instruction in, decoded control bundle out.
// The BIST drives instr through tb; the control unit answers through cu.
interface control_unit_if;
  logic [31:0] instr;
  logic        WEN;
  logic        brnch_eq;
  logic        brnch_ne;
  logic        jmp;
  logic        JR;
  logic        JALflag;
  logic        cuDRE;
  logic        cuDWE;
  logic        cuIRE;
  logic        cuHALT;
  logic [3:0]  ALUOP;
  logic        ALUsrc;
  logic        EXTop;
  logic        RegDst;
  logic        MemToReg;
  logic        SHIFTflag;
  logic        LUIflag;

  modport tb (
    output instr,
    input  WEN, brnch_eq, brnch_ne, jmp, JR, JALflag,
    input  cuDRE, cuDWE, cuIRE, cuHALT, ALUOP,
    input  ALUsrc, EXTop, RegDst, MemToReg, SHIFTflag, LUIflag
  );

  modport cu (
    input  instr,
    output WEN, brnch_eq, brnch_ne, jmp, JR, JALflag,
    output cuDRE, cuDWE, cuIRE, cuHALT, ALUOP,
    output ALUsrc, EXTop, RegDst, MemToReg, SHIFTflag, LUIflag
  );
endinterface

// File: rtl/cu_bist.sv
// Control unit self-test: LFSR instruction stream in, MISR of the
// decoded control bundle out, compared against a golden signature.
module cu_bist #(
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'h00000001
) (
  input  logic              CLK,
  input  logic              nRST,
  control_unit_if.tb        cuif,
  input  logic              start,
  input  logic [31:0]       expected_sig,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [31:0]       signature
);

  localparam int CW = $clog2(NUM_VECTORS + 1);
  localparam logic [31:0] SEED_EFF =
    (SEED == 32'h0) ? 32'h00000001 : SEED;
  localparam logic [CW-1:0] LAST = CW'(NUM_VECTORS - 1);
  localparam logic [31:0] TAPS = 32'h80200003;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [31:0]   misr_q, misr_d;
  logic [31:0]   instr_q, instr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic [19:0]   pkt;
  logic [31:0]   lfsr_step;
  logic [31:0]   misr_step;

  always_comb begin
    pkt = {cuif.WEN, cuif.brnch_eq, cuif.brnch_ne,
           cuif.jmp, cuif.JR, cuif.JALflag,
           cuif.cuDRE, cuif.cuDWE, cuif.cuIRE,
           cuif.cuHALT, cuif.ALUOP,
           cuif.ALUsrc, cuif.EXTop, cuif.RegDst,
           cuif.MemToReg, cuif.SHIFTflag, cuif.LUIflag};

    lfsr_step = {1'b0, lfsr_q[31:1]}
              ^ (lfsr_q[0] ? TAPS : 32'h0);
    misr_step = {misr_q[30:0], 1'b0}
              ^ (misr_q[31] ? POLY : 32'h0)
              ^ {12'h000, pkt};

    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          lfsr_d  = SEED_EFF;
          misr_d  = 32'h0;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        lfsr_d = lfsr_step;
        misr_d = misr_step;
        if (cnt_q == LAST) begin
          state_d = DONE;
          pass_d  = (misr_step == expected_sig);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // instr follows the LFSR only while running, straight from a flop
    instr_d = (state_d == RUN) ? lfsr_d : 32'h0;
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_EFF;
      misr_q  <= 32'h0;
      instr_q <= 32'h0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign cuif.instr = instr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign signature  = misr_q;

endmodule

// File: tb/tb_cu_bist.sv
// Directed bench for cu_bist with a small behavioural control unit
// and an independent LFSR/MISR reference for golden signatures.
module tb_cu_bist;

  logic        CLK;
  logic        nRST;
  logic        start4, start256;
  logic [31:0] exp4, exp256;
  logic        busy4, done4, pass4;
  logic        busy256, done256, pass256;
  logic [31:0] sig4, sig256;
  logic        fault;

  int n_chk;
  int n_fail;

  control_unit_if cu4 ();
  control_unit_if cu256 ();

  cu_bist #(.NUM_VECTORS(4), .SEED(32'h1)) u4 (
    .CLK(CLK), .nRST(nRST), .cuif(cu4.tb),
    .start(start4), .expected_sig(exp4),
    .busy(busy4), .done(done4), .pass(pass4),
    .signature(sig4)
  );

  cu_bist #(.NUM_VECTORS(256), .SEED(32'h1)) u256 (
    .CLK(CLK), .nRST(nRST), .cuif(cu256.tb),
    .start(start256), .expected_sig(exp256),
    .busy(busy256), .done(done256), .pass(pass256),
    .signature(sig256)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [19:0] cu_decode(input logic [31:0] i);
    logic [5:0] op, fn;
    logic wen, beq, bne, jmp, jr, jal, dre, dwe, ire, halt;
    logic asrc, ext, rdst, m2r, sh, lui;
    logic [3:0] aop;
    op = i[31:26];
    fn = i[5:0];
    {wen, beq, bne, jmp, jr, jal, dre, dwe, halt} = '0;
    {asrc, ext, rdst, m2r, sh, lui} = '0;
    ire = 1'b1;
    aop = op[3:0];
    case (op)
      6'h00: begin
        wen = 1'b1; rdst = 1'b1; aop = fn[3:0];
        jr = (fn == 6'h08); sh = (fn[5:2] == 4'h0);
      end
      6'h02: jmp = 1'b1;
      6'h03: begin jmp = 1'b1; jal = 1'b1; wen = 1'b1; end
      6'h04: beq = 1'b1;
      6'h05: bne = 1'b1;
      6'h0F: begin wen = 1'b1; lui = 1'b1; asrc = 1'b1; end
      6'h23: begin
        wen = 1'b1; dre = 1'b1; asrc = 1'b1;
        ext = 1'b1; m2r = 1'b1; aop = 4'h0;
      end
      6'h2B: begin
        dwe = 1'b1; asrc = 1'b1; ext = 1'b1; aop = 4'h0;
      end
      6'h3F: begin halt = 1'b1; ire = 1'b0; end
      default: if (op[5:3] == 3'b001) begin
        wen = 1'b1; asrc = 1'b1; ext = ~op[2];
      end
    endcase
    return {wen, beq, bne, jmp, jr, jal, dre, dwe, ire, halt,
            aop, asrc, ext, rdst, m2r, sh, lui};
  endfunction

  // ALUOP[0] sits at bit 6 of the packed bundle
  logic [19:0] mask256;
  assign mask256 = fault ? 20'hFFFBF : 20'hFFFFF;

  assign {cu4.WEN, cu4.brnch_eq, cu4.brnch_ne, cu4.jmp,
          cu4.JR, cu4.JALflag, cu4.cuDRE, cu4.cuDWE,
          cu4.cuIRE, cu4.cuHALT, cu4.ALUOP, cu4.ALUsrc,
          cu4.EXTop, cu4.RegDst, cu4.MemToReg,
          cu4.SHIFTflag, cu4.LUIflag} = cu_decode(cu4.instr);

  assign {cu256.WEN, cu256.brnch_eq, cu256.brnch_ne,
          cu256.jmp, cu256.JR, cu256.JALflag, cu256.cuDRE,
          cu256.cuDWE, cu256.cuIRE, cu256.cuHALT,
          cu256.ALUOP, cu256.ALUsrc, cu256.EXTop,
          cu256.RegDst, cu256.MemToReg, cu256.SHIFTflag,
          cu256.LUIflag} = cu_decode(cu256.instr) & mask256;

  function automatic logic [31:0] model_sig(input int n, input bit flt);
    logic [31:0] s, m;
    logic [19:0] p;
    s = 32'h1;
    m = 32'h0;
    for (int k = 0; k < n; k++) begin
      p = cu_decode(s);
      if (flt) p[6] = 1'b0;
      m = {m[30:0], 1'b0} ^ (m[31] ? 32'h04C11DB7 : 32'h0)
        ^ {12'h000, p};
      s = {1'b0, s[31:1]} ^ (s[0] ? 32'h80200003 : 32'h0);
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run256(input bit hold, output int nb);
    int guard;
    start256 = 1'b1;
    tick();
    if (!hold) start256 = 1'b0;
    nb = 0;
    guard = 0;
    while (!done256 && guard < 400) begin
      if (busy256) nb++;
      guard++;
      tick();
    end
  endtask

  logic [31:0] vec4 [4];
  logic [31:0] gold, sig_a;
  int nb;

  initial begin
    n_chk = 0;
    n_fail = 0;
    vec4[0] = 32'h00000001;
    vec4[1] = 32'h80200003;
    vec4[2] = 32'hC0300002;
    vec4[3] = 32'h60180001;
    gold = model_sig(256, 1'b0);
    nRST = 1'b0;
    start4 = 1'b0;
    start256 = 1'b0;
    exp4 = model_sig(4, 1'b0);
    exp256 = gold;
    fault = 1'b0;

    tick();
    tick();
    nRST = 1'b1;
    tick();

    // get u4 running, then pull reset mid-cycle
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("pre_rst_busy", {31'h0, busy4}, 32'h1);
    #4;
    nRST = 1'b0;
    #1;
    chk("rst_busy", {31'h0, busy4}, 32'h0);
    chk("rst_done", {31'h0, done4}, 32'h0);
    chk("rst_pass", {31'h0, pass4}, 32'h0);
    chk("rst_sig", sig4, 32'h0);
    chk("rst_instr", cu4.instr, 32'h0);
    tick();
    nRST = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_state",
          {28'h0, busy4, done4, busy256, done256}, 32'h0);
    end
    chk("idle_instr", cu256.instr, 32'h0);

    // 4-vector sequence
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("vec_instr", cu4.instr, vec4[k]);
      chk("vec_busy", {31'h0, busy4}, 32'h1);
      tick();
    end
    chk("vec_done", {30'h0, busy4, done4}, 32'h1);
    chk("vec_instr0", cu4.instr, 32'h0);
    chk("vec_pass", {31'h0, pass4}, 32'h1);
    chk("vec_sig", sig4, exp4);

    // 256-vector golden match
    run256(1'b0, nb);
    chk("gold_len", nb, 256);
    chk("gold_done", {30'h0, busy256, done256}, 32'h1);
    chk("gold_pass", {31'h0, pass256}, 32'h1);
    chk("gold_sig", sig256, gold);
    exp256 = gold ^ 32'h1;
    tick();
    chk("pass_hold", {31'h0, pass256}, 32'h1);

    // wrong golden
    run256(1'b0, nb);
    chk("bad_exp_pass", {31'h0, pass256}, 32'h0);
    chk("bad_exp_sig", sig256, gold);

    // ALUOP[0] stuck-at-0 in the control unit
    exp256 = gold;
    fault = 1'b1;
    run256(1'b0, nb);
    chk("fault_pass", {31'h0, pass256}, 32'h0);
    fault = 1'b0;

    // start held: back-to-back runs, identical signatures
    run256(1'b1, nb);
    chk("hold1_len", nb, 256);
    sig_a = sig256;
    chk("hold1_pass", {31'h0, pass256}, 32'h1);
    run256(1'b1, nb);
    chk("hold2_len", nb, 256);
    chk("hold2_sig", sig256, sig_a);
    start256 = 1'b0;
    tick();
    chk("hold_end", {30'h0, busy256, done256}, 32'h1);

    // reset in the middle of a run
    start256 = 1'b1;
    tick();
    start256 = 1'b0;
    for (int k = 0; k < 100; k++) tick();
    chk("mid_busy", {31'h0, busy256}, 32'h1);
    #2;
    nRST = 1'b0;
    #1;
    chk("mid_rst_busy", {31'h0, busy256}, 32'h0);
    chk("mid_rst_sig", sig256, 32'h0);
    chk("mid_rst_instr", cu256.instr, 32'h0);
    tick();
    nRST = 1'b1;
    tick();
    run256(1'b0, nb);
    chk("post_len", nb, 256);
    chk("post_pass", {31'h0, pass256}, 32'h1);
    chk("post_sig", sig256, gold);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
